// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//
// Purpose:
//   Shared types and constants for the hazard detection unit. The unit keeps a
//   small shadow pipeline of in-flight destination registers. Each stage of
//   that shadow pipeline is described by a slot_t record.
//
// Contents:
//   REG_W      - register index width (16 architectural registers)
//   slot_t     - one shadow pipeline slot {dest, wb_en, mem_read}
//   BUBBLE     - the empty slot (all fields zero)
//   slot_hit() - true when a slot will write the given register
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int REG_W = 4;

    // One in-flight instruction as seen by the hazard unit: where it writes,
    // whether it writes at all, and whether its result comes from memory.
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } slot_t;

    // An empty slot. Inserted on stalls and flushes, and used as the reset value.
    localparam slot_t BUBBLE = '0;

    // A slot only produces a RAW hit if it actually writes back. A matching
    // register number on a non-writing slot is not a dependency.
    function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] r);
        return s.wb_en && (s.dest == r);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//
// Purpose:
//   Bundles the request/response signals between the ID stage (master) and
//   the hazard scoreboard (slave).
//
// Signals (master -> slave):
//   hazard_rn, hazard_rdm   - source registers of the instruction in ID
//   hazard_two_src          - instruction in ID reads hazard_rdm
//   id_use_rn               - instruction in ID reads Rn
//   id_dest, id_wb_en       - destination and write enable of the ID instruction
//   id_mem_read             - ID instruction is a load
//   flush                   - taken branch in EXE, ID/IF contents discarded
//   fwd_en                  - forwarding unit active
//
// Signals (slave -> master):
//   hazard                  - freeze IF, IF/ID and bubble ID/EXE
//   exe_dest, exe_wb_en     - EXE shadow slot contents
//   mem_dest, mem_wb_en     - MEM shadow slot contents
//   stall_count             - saturating count of stalled cycles
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic [REG_W-1:0] hazard_rn;
    logic [REG_W-1:0] hazard_rdm;
    logic             hazard_two_src;
    logic             id_use_rn;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_read;
    logic             flush;
    logic             fwd_en;

    logic             hazard;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output hazard_rn, hazard_rdm, hazard_two_src, id_use_rn,
               id_dest, id_wb_en, id_mem_read, flush, fwd_en,
        input  hazard, exe_dest, exe_wb_en, mem_dest, mem_wb_en, stall_count
    );

    modport slave (
        input  hazard_rn, hazard_rdm, hazard_two_src, id_use_rn,
               id_dest, id_wb_en, id_mem_read, flush, fwd_en,
        output hazard, exe_dest, exe_wb_en, mem_dest, mem_wb_en, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_slot_reg.sv
// -----------------------------------------------------------------------------
// hazard_slot_reg
//
// Purpose:
//   One stage of the hazard unit's shadow pipeline. Holds a single slot_t
//   record and either loads the incoming record or a bubble.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset, clears the slot to BUBBLE
//   bubble  in   load BUBBLE instead of d on this edge
//   d       in   slot record presented by the previous stage
//   q       out  registered slot record
// -----------------------------------------------------------------------------
module hazard_slot_reg
    import hazard_scoreboard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    // Reset and bubble insertion both leave an empty slot behind, so a
    // stalled or flushed instruction can never be mistaken for a producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (bubble) begin
            q <= BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Hazard detection unit for the 5-stage pipeline. Tracks the destination
//   registers of the two instructions ahead of ID (EXE slot, MEM slot) and
//   raises `hazard` when the instruction in ID reads a register one of them
//   is still going to write. With forwarding enabled only a load in EXE
//   feeding the ID instruction causes a stall. WB needs no slot because the
//   register file writes on the falling edge, so ID already sees WB results.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   sb          slave modport of hazard_scoreboard_if (ID requests in,
//               hazard / slot debug / stall_count out)
//
// Parameters:
//   CNT_W       width of the saturating stall counter (must match sb)
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t            id_slot;
    slot_t            exe_slot;
    slot_t            mem_slot;
    logic             exe_bubble;

    logic             hit_exe_rn;
    logic             hit_exe_rdm;
    logic             hit_mem_rn;
    logic             hit_mem_rdm;
    logic             hazard_int;

    logic [CNT_W-1:0] stall_q;

    // The MEM slot's load flag travels along for symmetry with the EXE slot
    // but is never consulted: by the time a load sits in MEM its data is
    // either forwardable or already covered by the non-forwarding rule.
    logic             unused_mem_read;

    // Package the ID instruction as the record it will become in EXE.
    always_comb begin
        id_slot          = BUBBLE;
        id_slot.dest     = sb.id_dest;
        id_slot.wb_en    = sb.id_wb_en;
        id_slot.mem_read = sb.id_mem_read;
    end

    // A stalled ID instruction must not advance, and a flushed one is being
    // discarded, so both cases push a bubble into EXE.
    assign exe_bubble = sb.flush || hazard_int;

    hazard_slot_reg u_exe_slot (
        .clk    (clk),
        .rst    (rst),
        .bubble (exe_bubble),
        .d      (id_slot),
        .q      (exe_slot)
    );

    // MEM always takes whatever was in EXE; bubbles arrive via the EXE slot.
    hazard_slot_reg u_mem_slot (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .d      (exe_slot),
        .q      (mem_slot)
    );

    // Source-vs-slot matches, already qualified by whether the ID instruction
    // actually reads that source.
    assign hit_exe_rn  = sb.id_use_rn      && slot_hit(exe_slot, sb.hazard_rn);
    assign hit_exe_rdm = sb.hazard_two_src && slot_hit(exe_slot, sb.hazard_rdm);
    assign hit_mem_rn  = sb.id_use_rn      && slot_hit(mem_slot, sb.hazard_rn);
    assign hit_mem_rdm = sb.hazard_two_src && slot_hit(mem_slot, sb.hazard_rdm);

    // Stall decision. Reset and flush win over any dependency: during reset
    // nothing should freeze, and a flushed ID instruction needs no operands.
    // With forwarding, ALU results in EXE/MEM are bypassed, so only a load
    // in EXE (data not ready until the end of MEM) forces a stall.
    always_comb begin
        hazard_int = 1'b0;
        if (rst || sb.flush) begin
            hazard_int = 1'b0;
        end else if (sb.fwd_en) begin
            hazard_int = exe_slot.mem_read && (hit_exe_rn || hit_exe_rdm);
        end else begin
            hazard_int = hit_exe_rn || hit_exe_rdm || hit_mem_rn || hit_mem_rdm;
        end
    end

    // Stall cycle counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (hazard_int && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign unused_mem_read = mem_slot.mem_read;

    assign sb.hazard      = hazard_int;
    assign sb.exe_dest    = exe_slot.dest;
    assign sb.exe_wb_en   = exe_slot.wb_en;
    assign sb.mem_dest    = mem_slot.dest;
    assign sb.mem_wb_en   = mem_slot.wb_en;
    assign sb.stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard. A reference model keeps the two
// most recently issued instructions (or bubbles) in a queue, youngest first,
// and derives the stall from the RAW rules directly. Directed scenarios cover
// the basic dependency cases; a randomized phase sweeps the rest.
// A small counter width is used so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int dest;
        bit wb;
        bit ld;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    // Issued instructions, index 0 = one ahead of ID, index 1 = two ahead.
    rec_t pipe[$];
    int   m_count;
    int   vectors;
    int   miscompares;

    // Instruction in ID needs a stall if it reads a register that an
    // instruction one or two ahead will write (no forwarding), or, with
    // forwarding, a register the load directly ahead of it will write.
    function automatic bit model_hazard();
        bit rn_near, rdm_near, rn_far, rdm_far;
        if (rst || bus.flush) return 1'b0;
        rn_near  = bus.id_use_rn      && pipe[0].wb && (pipe[0].dest == int'(bus.hazard_rn));
        rdm_near = bus.hazard_two_src && pipe[0].wb && (pipe[0].dest == int'(bus.hazard_rdm));
        rn_far   = bus.id_use_rn      && pipe[1].wb && (pipe[1].dest == int'(bus.hazard_rn));
        rdm_far  = bus.hazard_two_src && pipe[1].wb && (pipe[1].dest == int'(bus.hazard_rdm));
        if (bus.fwd_en) return pipe[0].ld && (rn_near || rdm_near);
        return rn_near || rdm_near || rn_far || rdm_far;
    endfunction

    function automatic void model_clear();
        rec_t b;
        b.dest = 0;
        b.wb   = 1'b0;
        b.ld   = 1'b0;
        pipe.delete();
        pipe.push_back(b);
        pipe.push_back(b);
        m_count = 0;
    endfunction

    // Present one ID instruction and settle to the falling edge for sampling.
    task automatic drive(input int rn, input int rdm, input bit two, input bit use_rn,
                         input int dest, input bit wb, input bit ld,
                         input bit fl, input bit fwd);
        bus.hazard_rn      = REG_W'(rn);
        bus.hazard_rdm     = REG_W'(rdm);
        bus.hazard_two_src = two;
        bus.id_use_rn      = use_rn;
        bus.id_dest        = REG_W'(dest);
        bus.id_wb_en       = wb;
        bus.id_mem_read    = ld;
        bus.flush          = fl;
        bus.fwd_en         = fwd;
        @(negedge clk);
    endtask

    // Clock edge: the model issues the ID instruction unless it stalls or is flushed.
    task automatic advance();
        bit   h;
        rec_t nr;
        h = model_hazard();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (h && m_count < CNT_MAX) m_count++;
            if (bus.flush || h) begin
                nr.dest = 0;
                nr.wb   = 1'b0;
                nr.ld   = 1'b0;
            end else begin
                nr.dest = int'(bus.id_dest);
                nr.wb   = bus.id_wb_en;
                nr.ld   = bus.id_mem_read;
            end
            pipe.push_front(nr);
            void'(pipe.pop_back());
        end
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (bus.hazard !== 1'b0 || bus.exe_wb_en !== 1'b0 || bus.mem_wb_en !== 1'b0 ||
            bus.exe_dest !== '0 || bus.mem_dest !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_slots: got hazard=%0b exe=%0b/%0d mem=%0b/%0d required all 0",
                     bus.hazard, bus.exe_wb_en, bus.exe_dest, bus.mem_wb_en, bus.mem_dest);
        end
        vectors++;
        if (bus.stall_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_count: got %0d required 0", bus.stall_count);
        end
        advance();
    endtask

    task automatic test_no_dep();
        reset_dut();
        drive(2, 3, 1, 1, 1, 1, 0, 0, 0);
        vectors++;
        if (bus.hazard !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nodep_first: got %0b required 0", bus.hazard);
        end
        advance();
        drive(3, 4, 1, 1, 2, 1, 0, 0, 0);
        vectors++;
        if (bus.hazard !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nodep_second: got %0b required 0", bus.hazard);
        end
        advance();
        vectors++;
        if (bus.stall_count !== '0 || bus.exe_dest !== 4'd2 || bus.mem_dest !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL nodep_state: got count=%0d exe=%0d mem=%0d required 0/2/1",
                     bus.stall_count, bus.exe_dest, bus.mem_dest);
        end
    endtask

    task automatic test_raw_nofwd();
        int stalls;
        reset_dut();
        drive(2, 3, 1, 1, 1, 1, 0, 0, 0);
        advance();
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 5, 1, 1, 2, 1, 0, 0, 0);
            vectors++;
            if (bus.hazard !== model_hazard()) begin
                miscompares++;
                $display("[TB] FAIL raw_hazard[%0d]: got %0b required %0b", i, bus.hazard, model_hazard());
            end
            if (bus.hazard === 1'b1) stalls++;
            if (i == 1) begin
                vectors++;
                if (bus.exe_wb_en !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL raw_bubble: got exe_wb_en=%0b required 0", bus.exe_wb_en);
                end
            end
            advance();
        end
        vectors++;
        if (stalls != 2) begin
            miscompares++;
            $display("[TB] FAIL raw_stall_len: got %0d required 2", stalls);
        end
        vectors++;
        if (bus.stall_count !== 4'd2) begin
            miscompares++;
            $display("[TB] FAIL raw_count: got %0d required 2", bus.stall_count);
        end
    endtask

    task automatic test_load_use();
        int stalls;
        for (int ld = 1; ld >= 0; ld--) begin
            reset_dut();
            drive(6, 0, 0, 1, 3, 1, ld[0], 0, 1);
            advance();
            stalls = 0;
            for (int i = 0; i < 4; i++) begin
                drive(6, 3, 1, 1, 4, 1, 0, 0, 1);
                if (bus.hazard === 1'b1) stalls++;
                advance();
            end
            vectors++;
            if (stalls != ld) begin
                miscompares++;
                $display("[TB] FAIL loaduse_len(ld=%0d): got %0d required %0d", ld, stalls, ld);
            end
        end
    endtask

    task automatic test_flush();
        reset_dut();
        drive(2, 3, 1, 1, 1, 1, 0, 0, 0);
        advance();
        drive(1, 5, 1, 1, 2, 1, 0, 1, 0);
        vectors++;
        if (bus.hazard !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_hazard: got %0b required 0", bus.hazard);
        end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (bus.exe_wb_en !== 1'b0 || bus.mem_dest !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL flush_bubble: got exe_wb_en=%0b mem_dest=%0d required 0/1",
                     bus.exe_wb_en, bus.mem_dest);
        end
        advance();
    endtask

    task automatic test_mov();
        reset_dut();
        drive(2, 3, 1, 1, 1, 1, 0, 0, 0);
        advance();
        drive(1, 0, 0, 0, 7, 1, 0, 0, 0);
        vectors++;
        if (bus.hazard !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mov_no_rn: got %0b required 0", bus.hazard);
        end
        advance();
    endtask

    task automatic test_reset_mid_stall();
        reset_dut();
        drive(2, 3, 1, 1, 1, 1, 0, 0, 0);
        advance();
        drive(1, 5, 1, 1, 2, 1, 0, 0, 0);
        advance();
        rst = 1'b1;
        drive(1, 5, 1, 1, 2, 1, 0, 0, 0);
        vectors++;
        if (bus.hazard !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_hazard: got %0b required 0", bus.hazard);
        end
        advance();
        rst = 1'b0;
        drive(1, 5, 1, 1, 2, 1, 0, 0, 0);
        vectors++;
        if (bus.hazard !== 1'b0 || bus.exe_wb_en !== 1'b0 || bus.mem_wb_en !== 1'b0 ||
            bus.exe_dest !== '0 || bus.mem_dest !== '0 || bus.stall_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_after: got hazard=%0b exe=%0b/%0d mem=%0b/%0d count=%0d required all 0",
                     bus.hazard, bus.exe_wb_en, bus.exe_dest, bus.mem_wb_en, bus.mem_dest, bus.stall_count);
        end
        advance();
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 30; i++) begin
            drive(15, 15, 1, 1, 15, 1, 0, 0, 0);
            vectors++;
            if (bus.hazard !== model_hazard()) begin
                miscompares++;
                $display("[TB] FAIL sat_hazard[%0d]: got %0b required %0b", i, bus.hazard, model_hazard());
            end
            advance();
        end
        vectors++;
        if (bus.stall_count !== CNT_W'(CNT_MAX)) begin
            miscompares++;
            $display("[TB] FAIL sat_count: got %0d required %0d", bus.stall_count, CNT_MAX);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3), ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
            vectors++;
            if (bus.hazard !== model_hazard()) begin
                miscompares++;
                $display("[TB] FAIL rnd_hazard[%0d]: got %0b required %0b", i, bus.hazard, model_hazard());
            end
            vectors++;
            if (bus.exe_wb_en !== pipe[0].wb || (pipe[0].wb && int'(bus.exe_dest) != pipe[0].dest) ||
                bus.mem_wb_en !== pipe[1].wb || (pipe[1].wb && int'(bus.mem_dest) != pipe[1].dest)) begin
                miscompares++;
                $display("[TB] FAIL rnd_slots[%0d]: got exe=%0b/%0d mem=%0b/%0d required exe=%0b/%0d mem=%0b/%0d",
                         i, bus.exe_wb_en, bus.exe_dest, bus.mem_wb_en, bus.mem_dest,
                         pipe[0].wb, pipe[0].dest, pipe[1].wb, pipe[1].dest);
            end
            vectors++;
            if (int'(bus.stall_count) != m_count) begin
                miscompares++;
                $display("[TB] FAIL rnd_count[%0d]: got %0d required %0d", i, bus.stall_count, m_count);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_clear();
        test_reset();
        test_no_dep();
        test_raw_nofwd();
        test_load_use();
        test_flush();
        test_mov();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard detection unit; the responder to the ID stage's hazard request outputs (hazardRn, hazardRdm, hazardTwoSrc).
- Drives the `hazard` freeze line consumed by Stage_IF, the IF/ID register and Stage_ID.
- Keeps its own two-slot shadow pipeline of destination registers (EXE slot, MEM slot), fed from the ID stage outputs, and flags RAW hazards against it.
- Supports a forwarding mode in which only load-use hazards stall.

Parameters:
REG_W, 4, register index width
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
hazard_rn  in  REG_W  source register Rn of instruction in ID
hazard_rdm  in  REG_W  second source (Rm, or Rd for STR) of instruction in ID
hazard_two_src  in  1  instruction in ID reads hazard_rdm
id_use_rn  in  1  instruction in ID reads Rn (0 for MOV/MVN/branch)
id_dest  in  REG_W  destination register of instruction in ID
id_wb_en  in  1  instruction in ID writes back
id_mem_read  in  1  instruction in ID is a load
flush  in  1  Branch_taken from EXE; ID/IF contents are discarded this cycle
fwd_en  in  1  forwarding unit active
hazard  out  1  freeze IF, IF/ID and insert bubble into ID/EXE
exe_dest  out  REG_W  EXE slot destination (debug/forwarding)
exe_wb_en  out  1  EXE slot valid write
mem_dest  out  REG_W  MEM slot destination
mem_wb_en  out  1  MEM slot valid write
stall_count  out  CNT_W  number of cycles hazard was 1, saturating

Behaviour:
- Reset (rst=1 at rising edge): EXE and MEM slots cleared (dest=0, wb_en=0, mem_read=0); stall_count=0. `hazard` is forced to 0 while rst=1.
- Slot update each rising edge (rst=0):
  - MEM slot <= EXE slot (dest, wb_en, mem_read).
  - EXE slot <= bubble (wb_en=0, mem_read=0, dest=0) if flush=1 or hazard=1.
  - Otherwise EXE slot <= {id_dest, id_wb_en, id_mem_read}.
- The WB stage needs no slot: the register file writes on the negative edge, so a WB value is readable by ID in the same cycle.
- `hazard` is combinational, with zero-cycle latency from inputs and slot state.
  - hitE(r) = exe_wb_en && r==exe_dest
  - hitM(r) = mem_wb_en && r==mem_dest
- fwd_en=0: hazard = (id_use_rn && (hitE(rn)||hitM(rn))) || (hazard_two_src && (hitE(rdm)||hitM(rdm))).
- fwd_en=1: hazard = exe_mem_read && ((id_use_rn && hitE(rn)) || (hazard_two_src && hitE(rdm))). The MEM slot is never a stall source in this mode.
- flush=1 forces hazard=0, because the ID instruction is being discarded. Flush has priority over hazard.
- A stall persists while the condition holds. Each stall cycle inserts a bubble, so the producer advances EXE->MEM->retired.
  - Without forwarding, a back-to-back dependency stalls exactly 2 cycles.
  - With forwarding, a load-use dependency stalls exactly 1 cycle.
- stall_count increments on each rising edge where hazard=1 and rst=0. It holds at 2^CNT_W-1.
- Register 15 gets no special treatment; matches on R15 stall like any other register.
- fwd_en may change at any cycle and takes effect combinationally.
- Reset mid-stall: the slots clear, so hazard drops in the first cycle after reset.

Decomposition:
- Shared package arm_pkg holds:
  - REG_W
  - a slot struct {dest, wb_en, mem_read}
  - the BUBBLE constant (all zero)
- One natural sub-module, hazard_slot_reg: a single slot register with synchronous reset and a bubble-insert input, instantiated twice (EXE, MEM).
- Comparison logic stays in the top module.

Test Plan:
1. Reset, then no dependencies: ADD R1 then ADD R2 reading R3, R4, fwd_en=0 -> hazard stays 0; stall_count=0.
2. fwd_en=0, ADD R1,... followed by SUB R2,R1,R5 (rn=1) -> hazard=1 for exactly 2 cycles; exe_wb_en=0 (bubble) after the first stall edge; stall_count=2.
3. fwd_en=1, LDR R3 (mem_read=1) followed by ADD R4,R6,R3 (two_src=1, rdm=3) -> hazard=1 for 1 cycle only; the same sequence with a non-load producer -> hazard=0.
4. A hazard condition present with flush=1 in the same cycle -> hazard=0; the EXE slot loads a bubble (exe_wb_en=0 next cycle).
5. MOV R7,#1 (id_use_rn=0, rn field=1) while R1 is in EXE, fwd_en=0 -> hazard=0.
6. rst asserted during the second stall cycle of scenario 2 -> hazard=0 during reset; slots and stall_count read 0 on the next cycle.
